// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Optional signed-overflow output ovf is built when SERIAL_SUBTRACTOR_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is honoured only in IDLE (one-cycle acceptance, no queueing);
  // busy is high for exactly the WIDTH RUN cycles; done pulses for one cycle when
  // diff/borrow are updated. Results hold until the next completed operation.
  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_d_sh;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             r_sa;
  logic             r_sb;
  logic             r_ovf;
`endif

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br_n;
  logic [WIDTH-1:0] w_d_next;
  logic             w_last;

  // Full-subtractor cell.
  assign w_a0     = r_a_sh[0];
  assign w_b0     = r_b_sh[0];
  assign w_d      = w_a0 ^ w_b0 ^ r_br;
  assign w_br_n   = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
  assign w_d_next = {w_d, r_d_sh};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_d_sh  <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_sa    <= a[WIDTH-1];
            r_sb    <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_d_sh <= w_d_next[WIDTH-1:1];
          r_br   <= w_br_n;
          r_cnt  <= r_cnt + CW'(1);
          // The final bit is folded straight into the outputs so they never expose partial results.
          if (w_last) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_diff   <= w_d_next;
            r_borrow <= w_br_n;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_ovf    <= (r_sa != r_sb) && (w_d != r_sa);
`endif
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf       = r_ovf;
`endif
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed WIDTH=8 vectors plus a WIDTH=4 sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic [1:0]   dbg_state;
  logic         obs_ovf;

  logic         s4;
  logic [3:0]   a4;
  logic [3:0]   b4;
  logic         busy4;
  logic         done4;
  logic [3:0]   diff4;
  logic         borrow4;
  logic [1:0]   dbg_state4;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf8;
  logic ovf4;
  assign obs_ovf = ovf8;
`else
  assign obs_ovf = 1'b0;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf8),
`endif
    .dbg_state(dbg_state)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf4),
`endif
    .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_diff = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf_eff(input logic eo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    return eo;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model for random operands: {ovf, borrow, diff}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    logic       ov;
    d  = {1'b0, x} - {1'b0, y};
    ov = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    return {ovf_eff(ov), d[W], d[W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else check("result", {obs_ovf, borrow, diff}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                    input logic [W-1:0] ed, input logic eb, input logic eo);
    int  lat;
    int  busy_n;
    bit  seen;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v;
    exp_q.push_back({ovf_eff(eo), eb, ed});
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    check("busy_on_accept", busy, 1);
    check("diff_held_in_run", diff, last_diff);
    lat = 0; busy_n = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
      else if (busy) busy_n++;
    end
    check("done_latency", lat, W + 1);
    check("busy_cycles", busy_n, W);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("diff_hold", diff, ed);
    last_diff = ed;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] oa[0:30];
  logic [W-1:0] ob[0:30];
  int           d0;
  bit           seen4;
  int           e4;

  initial begin
    start = 0; a = '0; b = '0; s4 = 0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

    // start held high with operands changing every cycle; accepts every W+2 cycles
    d0 = done_cnt;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b1;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      oa[i] = a; ob[i] = b;
      if (i % (W + 2) == 0) exp_q.push_back(model(oa[i], ob[i]));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("b2b_done_count", done_cnt - d0, 4);
    check("b2b_queue_empty", exp_q.size(), 0);
    last_diff = model(oa[30], ob[30]) >> 0;

    op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

    // asynchronous reset in the 4th RUN cycle
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_diff", diff, 0);
    check("midrun_rst_borrow", borrow, 0);
    check("midrun_rst_state", dbg_state, 0);
    check("midrun_rst_ovf", obs_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    last_diff = '0;
    op(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1);

    op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    op(8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);
    op(8'hC9, 8'h00, 8'hC9, 1'b0, 1'b0);

    // exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        @(negedge clk);
        s4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib);
        @(posedge clk); #1;
        s4 = 1'b0;
        seen4 = 0;
        for (int k = 0; k < 12 && !seen4; k++) begin
          @(negedge clk);
          if (done4) seen4 = 1;
        end
        e4 = ((ia - ib) & 15) | ((ia < ib) ? 16 : 0);
        check("sweep_done", seen4, 1);
        check("sweep_result", {borrow4, diff4}, e4);
      end
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
